// File: rtl/seq_sdiv_pkg.sv
// Shared types and helpers for the sequential signed divider.
package seq_sdiv_pkg;

    localparam int MAXW = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Conditional two's-complement negate; callers zero-extend to MAXW and truncate back.
    function automatic logic [MAXW-1:0] cond_neg(input logic [MAXW-1:0] v, input logic neg);
        return neg ? (~v + MAXW'(1)) : v;
    endfunction

endpackage

// File: rtl/seq_sdiv_if.sv
// Start/done handshake and operand/result bus of the sequential signed divider.
interface seq_sdiv_if #(parameter int DATAWIDTH = 8);

    logic                 start;
    logic [DATAWIDTH-1:0] a;
    logic [DATAWIDTH-1:0] b;
    logic [DATAWIDTH-1:0] quot;
    logic [DATAWIDTH-1:0] rem;
    logic                 busy;
    logic                 done;
    logic                 div_by_zero;

    modport master (output start, a, b, input quot, rem, busy, done, div_by_zero);
    modport slave  (input start, a, b, output quot, rem, busy, done, div_by_zero);

endinterface

// File: rtl/seq_sdiv_div_step.sv
// One restoring-division step on magnitudes: shift in a dividend bit, trial-subtract.
module seq_sdiv_div_step #(
    parameter int DATAWIDTH = 8
) (
    input  logic [DATAWIDTH-1:0] prem,
    input  logic                 din,
    input  logic [DATAWIDTH-1:0] dvs,
    output logic [DATAWIDTH-1:0] prem_nxt,
    output logic                 qbit
);

    logic [DATAWIDTH:0] shifted;
    logic [DATAWIDTH:0] diff;

    // prem < dvs always holds, so shifted < 2*dvs and bit MSB of diff is the borrow.
    assign shifted  = {prem, din};
    assign diff     = shifted - {1'b0, dvs};
    assign qbit     = ~diff[DATAWIDTH];
    assign prem_nxt = qbit ? diff[DATAWIDTH-1:0] : shifted[DATAWIDTH-1:0];

endmodule

// File: rtl/seq_sdiv.sv
// Multi-cycle signed divider: restoring division on magnitudes, one bit per cycle, sign fix-up in FIN.
module seq_sdiv
    import seq_sdiv_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic        Clk,
    input  logic        Rst,
    seq_sdiv_if.slave   bus
);

    localparam int CW = $clog2(DATAWIDTH + 1);

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [DATAWIDTH-1:0] prem, dq, dvs;
    logic                 sign_a, sign_b, dbz;
    logic [DATAWIDTH-1:0] prem_nxt;
    logic                 qbit;
    logic [DATAWIDTH-1:0] quot_r, rem_r;
    logic                 done_r, dbz_r;

    seq_sdiv_div_step #(.DATAWIDTH(DATAWIDTH)) u_step (
        .prem     (prem),
        .din      (dq[DATAWIDTH-1]),
        .dvs      (dvs),
        .prem_nxt (prem_nxt),
        .qbit     (qbit)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = (bus.b == '0) ? FIN : CALC;
            CALC: if (cnt == CW'(1)) state_nxt = FIN;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // dq holds the dividend magnitude and fills with quotient bits from the LSB as it shifts out.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt    <= '0;
            prem   <= '0;
            dq     <= '0;
            dvs    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            dbz    <= 1'b0;
            quot_r <= '0;
            rem_r  <= '0;
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
        end else begin
            done_r <= (state == FIN);
            case (state)
                IDLE: if (bus.start) begin
                    sign_a <= bus.a[DATAWIDTH-1];
                    sign_b <= bus.b[DATAWIDTH-1];
                    dq     <= DATAWIDTH'(cond_neg(MAXW'(bus.a), bus.a[DATAWIDTH-1]));
                    dvs    <= DATAWIDTH'(cond_neg(MAXW'(bus.b), bus.b[DATAWIDTH-1]));
                    prem   <= '0;
                    cnt    <= CW'(DATAWIDTH);
                    dbz    <= (bus.b == '0);
                end
                CALC: begin
                    prem <= prem_nxt;
                    dq   <= {dq[DATAWIDTH-2:0], qbit};
                    cnt  <= cnt - CW'(1);
                end
                FIN: begin
                    dbz_r <= dbz;
                    // On divide-by-zero dq still holds |a|, so re-signing it recovers a.
                    if (dbz) begin
                        quot_r <= '1;
                        rem_r  <= DATAWIDTH'(cond_neg(MAXW'(dq), sign_a));
                    end else begin
                        quot_r <= DATAWIDTH'(cond_neg(MAXW'(dq), sign_a ^ sign_b));
                        rem_r  <= DATAWIDTH'(cond_neg(MAXW'(prem), sign_a));
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.quot        = quot_r;
    assign bus.rem         = rem_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_sdiv.sv
// Directed plus random checks of seq_sdiv against an integer-arithmetic reference model.
module tb_seq_sdiv;

    localparam int W = 8;

    logic Clk = 1'b0;
    logic Rst;
    int   ncmp  = 0;
    int   nfail = 0;
    int   edges = 0;

    seq_sdiv_if #(.DATAWIDTH(W)) dif();

    seq_sdiv #(.DATAWIDTH(W)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (dif.slave)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) edges++;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // C-style truncating division on signed ints; divide-by-zero gives all ones / dividend.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
        int sa, sb, qi, ri;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) begin
            q = '1; r = a; z = 1'b1;
        end else begin
            qi = sa / sb; ri = sa % sb;
            q = qi[W-1:0]; r = ri[W-1:0]; z = 1'b0;
        end
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, output int e0);
        dif.a = a; dif.b = b; dif.start = 1'b1;
        @(posedge Clk); #1;
        e0 = edges;
        dif.start = 1'b0;
        dif.a = W'($urandom);
        dif.b = W'($urandom);
    endtask

    task automatic wait_done(input int e0, output int lat);
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            if (dif.done === 1'b1) begin
                lat = edges - e0;
                break;
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
        logic [W-1:0] q, r;
        logic z;
        model(a, b, q, r, z);
        check($sformatf("%s latency", tag), lat, (b == '0) ? 1 : W + 1);
        check($sformatf("%s quot", tag), dif.quot, q);
        check($sformatf("%s rem", tag), dif.rem, r);
        check($sformatf("%s dbz", tag), dif.div_by_zero, z);
    endtask

    task automatic run_case(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        int e0, lat;
        issue(a, b, e0);
        check($sformatf("%s busy", tag), dif.busy, 1'b1);
        wait_done(e0, lat);
        check_result(tag, a, b, lat);
        @(posedge Clk); #1;
        check($sformatf("%s done_clear", tag), dif.done, 1'b0);
    endtask

    initial begin
        int e0, lat, ndone;
        logic [W-1:0] ra, rb;

        Rst = 1'b1; dif.start = 1'b0; dif.a = '0; dif.b = '0;
        #12;
        check("reset quot", dif.quot, 8'h00);
        check("reset rem",  dif.rem, 8'h00);
        check("reset done", dif.done, 1'b0);
        check("reset busy", dif.busy, 1'b0);
        check("reset dbz",  dif.div_by_zero, 1'b0);
        Rst = 1'b0;
        @(posedge Clk); #1;

        run_case(8'd100, 8'd7, "100/7");
        run_case(8'h9C,  8'd7, "-100/7");
        run_case(8'd100, 8'hF9, "100/-7");
        run_case(8'h9C,  8'hF9, "-100/-7");
        run_case(8'h80,  8'hFF, "-128/-1");
        run_case(8'h80,  8'h01, "-128/1");
        run_case(8'd5,   8'd0, "5/0");
        run_case(8'd9,   8'd3, "9/3");

        // Start while busy is ignored; start in the done cycle is accepted.
        issue(8'd100, 8'd7, e0);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        dif.start = 1'b1; dif.a = 8'd50; dif.b = 8'd5;
        @(posedge Clk); #1;
        dif.start = 1'b0;
        check("ignored busy", dif.busy, 1'b1);
        wait_done(e0, lat);
        check_result("ignored 100/7", 8'd100, 8'd7, lat);
        issue(8'd50, 8'd5, e0);
        wait_done(e0, lat);
        check_result("b2b 50/5", 8'd50, 8'd5, lat);
        @(posedge Clk); #1;

        // Async reset mid-CALC aborts with no trailing done.
        issue(8'd100, 8'd7, e0);
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk); #1;
        end
        #2 Rst = 1'b1;
        #1;
        check("abort quot", dif.quot, 8'h00);
        check("abort rem",  dif.rem, 8'h00);
        check("abort done", dif.done, 1'b0);
        check("abort busy", dif.busy, 1'b0);
        check("abort dbz",  dif.div_by_zero, 1'b0);
        #2 Rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge Clk); #1;
            if (dif.done === 1'b1) ndone++;
        end
        check("abort no_done", ndone, 0);
        check("abort idle", dif.busy, 1'b0);
        run_case(8'd9, 8'd2, "post-reset 9/2");

        for (int i = 0; i < 25; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            run_case(ra, rb, $sformatf("rand %0d %0h/%0h", i, ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
